// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
// Shared image-stream definitions for the 3x3 window builder and the
// RGB444 kernel filters that consume its output.
//   PIX_W          : bits per pixel, RGB444 packed {R[11:8],G[7:4],B[3:0]}
//   R_LSB/G_LSB/B_LSB, CH_W : colour channel field positions
//   TAP_C..TAP_DR  : LSB of each 12-bit slot inside the packed window
//   WIN_W          : width of the packed 3x3 window
// ---------------------------------------------------------------------------
package img_pkg;

    localparam int PIX_W = 12;
    localparam int CH_W  = 4;

    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    // Window slots, MSB to LSB: centre, left, right, up, down, then diagonals.
    localparam int TAP_C  = 8 * PIX_W;
    localparam int TAP_L  = 7 * PIX_W;
    localparam int TAP_R  = 6 * PIX_W;
    localparam int TAP_U  = 5 * PIX_W;
    localparam int TAP_D  = 4 * PIX_W;
    localparam int TAP_UL = 3 * PIX_W;
    localparam int TAP_UR = 2 * PIX_W;
    localparam int TAP_DL = 1 * PIX_W;
    localparam int TAP_DR = 0;

    localparam int WIN_W = 9 * PIX_W;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/line_window_3x3_line_ram.sv
// ---------------------------------------------------------------------------
// line_ram
// One line of pixel storage. Single clock, synchronous read with one cycle
// latency, read-before-write: a read and write to the same address in the
// same cycle returns the previously stored word.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable; rdata holds its value while re is low
//   raddr  in   read address
//   rdata  out  registered read data
// ---------------------------------------------------------------------------
module line_ram #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // The storage array carries no reset; the window logic never emits a
    // line-buffer word before the current frame has written it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_window_3x3.sv
// ---------------------------------------------------------------------------
// line_window_3x3
// Builds the 3x3 neighbourhood of every interior pixel of a raster stream
// using two line buffers and a 3x3 tap register array, and emits it as one
// packed window per interior pixel for downstream 3x3 filters.
// Ports:
//   clk           in   clock
//   reset         in   asynchronous, active-high
//   pix_in        in   PIX_W input pixel
//   pix_valid     in   pix_in valid this cycle (no back-pressure)
//   sof           in   with pix_valid: this pixel is (0,0) of a new frame
//   window_out    out  9*PIX_W packed window, slots C,L,R,U,D,UL,UR,DL,DR
//   window_valid  out  one-cycle pulse per window
//   eof           out  marks the last window of the frame
//   overflow      out  sticky: pixel arrived after the frame completed
//   win_x, win_y  out  window centre coordinates (only with WINDOW_COORD_EN)
// Optional feature macro: WINDOW_COORD_EN
// ---------------------------------------------------------------------------
module line_window_3x3
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIX_W-1:0]              pix_in,
    input  logic                          pix_valid,
    input  logic                          sof,
    output logic [WIN_W-1:0]              window_out,
    output logic                          window_valid,
    output logic                          eof,
`ifdef WINDOW_COORD_EN
    output logic                          overflow,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_y
`else
    output logic                          overflow
`endif
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;
    logic          frame_done_q, frame_done_d;
    logic          overflow_q, overflow_d;

    logic          accept;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;

    logic          s1_valid_q, s1_valid_d;
    logic [XW-1:0] s1_x_q, s1_x_d;
    logic [YW-1:0] s1_y_q, s1_y_d;
    pix_t          s1_pix_q, s1_pix_d;

    pix_t          ram0_rdata;
    pix_t          ram1_rdata;

    // tap_q[row][col]: row 0 is two lines up, row 2 the current line;
    // col 2 is the newest column.
    logic [2:0][2:0][PIX_W-1:0] tap_q, tap_d;

    logic          window_valid_q, window_valid_d;
    logic          eof_q, eof_d;

    // Position of the incoming pixel and frame bookkeeping. A pixel flagged
    // sof is always (0,0) and is accepted even after the frame has finished;
    // anything else after frame completion is dropped and flagged.
    always_comb begin
        accept       = pix_valid && (sof || !frame_done_q);
        cur_x        = sof ? '0 : col_q;
        cur_y        = sof ? '0 : row_q;
        col_d        = col_q;
        row_d        = row_q;
        frame_done_d = frame_done_q;
        overflow_d   = overflow_q;

        if (pix_valid && sof) begin
            frame_done_d = 1'b0;
            overflow_d   = 1'b0;
        end

        if (accept) begin
            if (cur_x == X_LAST) begin
                col_d = '0;
                if (cur_y == Y_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = cur_y + 1'b1;
                end
            end else begin
                col_d = cur_x + 1'b1;
                row_d = cur_y;
            end
        end else if (pix_valid) begin
            overflow_d = 1'b1;
        end
    end

    // Stage 1 captures the accepted pixel and its position while the line
    // RAMs are read; the registers hold through input gaps.
    always_comb begin
        s1_valid_d = accept;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_pix_d   = s1_pix_q;
        if (accept) begin
            s1_x_d   = cur_x;
            s1_y_d   = cur_y;
            s1_pix_d = pix_in;
        end
    end

    // RAM0 holds the previous line. RAM1 holds the line before that and is
    // refilled one cycle later with the word RAM0 returned, once it is out.
    line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_ram0 (
        .clk   (clk),
        .we    (accept),
        .waddr (cur_x),
        .wdata (pix_in),
        .re    (accept),
        .raddr (cur_x),
        .rdata (ram0_rdata)
    );

    line_ram #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (PIX_W)
    ) u_ram1 (
        .clk   (clk),
        .we    (s1_valid_q),
        .waddr (s1_x_q),
        .wdata (ram0_rdata),
        .re    (accept),
        .raddr (cur_x),
        .rdata (ram1_rdata)
    );

    // Stage 2 shifts the taps one column left and inserts the new column.
    // A window exists only once two full columns and two full lines of the
    // current frame sit behind the newest pixel, which also keeps stale
    // line-buffer contents from an abandoned frame out of every window.
    always_comb begin
        tap_d          = tap_q;
        window_valid_d = 1'b0;
        eof_d          = 1'b0;
        if (s1_valid_q) begin
            for (int r = 0; r < 3; r++) begin
                tap_d[r][0] = tap_q[r][1];
                tap_d[r][1] = tap_q[r][2];
            end
            tap_d[0][2]    = ram1_rdata;
            tap_d[1][2]    = ram0_rdata;
            tap_d[2][2]    = s1_pix_q;
            window_valid_d = (s1_x_q >= XW'(2)) && (s1_y_q >= YW'(2));
            eof_d          = (s1_x_q == X_LAST) && (s1_y_q == Y_LAST);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q          <= '0;
            row_q          <= '0;
            frame_done_q   <= 1'b0;
            overflow_q     <= 1'b0;
            s1_valid_q     <= 1'b0;
            s1_x_q         <= '0;
            s1_y_q         <= '0;
            s1_pix_q       <= '0;
            tap_q          <= '0;
            window_valid_q <= 1'b0;
            eof_q          <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_q          <= row_d;
            frame_done_q   <= frame_done_d;
            overflow_q     <= overflow_d;
            s1_valid_q     <= s1_valid_d;
            s1_x_q         <= s1_x_d;
            s1_y_q         <= s1_y_d;
            s1_pix_q       <= s1_pix_d;
            tap_q          <= tap_d;
            window_valid_q <= window_valid_d;
            eof_q          <= eof_d;
        end
    end

`ifdef WINDOW_COORD_EN
    logic [XW-1:0] win_x_q, win_x_d;
    logic [YW-1:0] win_y_q, win_y_d;

    // The centre lags the newest pixel by one column and one line.
    always_comb begin
        win_x_d = win_x_q;
        win_y_d = win_y_q;
        if (window_valid_d) begin
            win_x_d = s1_x_q - 1'b1;
            win_y_d = s1_y_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_x_q <= '0;
            win_y_q <= '0;
        end else begin
            win_x_q <= win_x_d;
            win_y_q <= win_y_d;
        end
    end

    assign win_x = win_x_q;
    assign win_y = win_y_q;
`endif

    assign window_out[TAP_C  +: PIX_W] = tap_q[1][1];
    assign window_out[TAP_L  +: PIX_W] = tap_q[1][0];
    assign window_out[TAP_R  +: PIX_W] = tap_q[1][2];
    assign window_out[TAP_U  +: PIX_W] = tap_q[0][1];
    assign window_out[TAP_D  +: PIX_W] = tap_q[2][1];
    assign window_out[TAP_UL +: PIX_W] = tap_q[0][0];
    assign window_out[TAP_UR +: PIX_W] = tap_q[0][2];
    assign window_out[TAP_DL +: PIX_W] = tap_q[2][0];
    assign window_out[TAP_DR +: PIX_W] = tap_q[2][2];

    assign window_valid = window_valid_q;
    assign eof          = eof_q;
    assign overflow     = overflow_q;

endmodule
